// File: rtl/fu_ctrl_pkg.sv
// rtl/fu_ctrl_pkg.sv - shared FSM state type, instruction field and status flag positions
package fu_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   localparam int INSTR_W  = 16;
   localparam int IR_MF    = 15;
   localparam int IR_S_HI  = 14;
   localparam int IR_S_LO  = 11;
   localparam int IR_DA_HI = 10;
   localparam int IR_DA_LO = 8;
   localparam int IR_AA_HI = 7;
   localparam int IR_AA_LO = 5;
   localparam int IR_BA_HI = 4;
   localparam int IR_BA_LO = 2;
   localparam int IR_WE    = 1;
   localparam int IR_COND  = 0;

   localparam int FLAG_W  = 6;
   localparam int FLAG_V  = 5;
   localparam int FLAG_C  = 4;
   localparam int FLAG_ZR = 3;
   localparam int FLAG_N  = 2;
   localparam int FLAG_IL = 1;
   localparam int FLAG_IR = 0;
endpackage

// File: rtl/fu_regfile.sv
// rtl/fu_regfile.sv - 8-entry register file, two operand read ports, a debug read port, one write port
// With R0_ZERO set, R0 reads as zero on every port and writes to it are dropped.
module fu_regfile #(
   parameter int DATA_W  = 16,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic [2:0]        wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [2:0]        ra_a,
   input  logic [2:0]        ra_b,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b,
   output logic [DATA_W-1:0] dbg_data
);
   logic [DATA_W-1:0] regs [8];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= '0;
         end
      end else if (we && !(R0_ZERO && wa == 3'd0)) begin
         regs[wa] <= wd;
      end
   end

   assign rd_a     = (R0_ZERO && ra_a == 3'd0)     ? '0 : regs[ra_a];
   assign rd_b     = (R0_ZERO && ra_b == 3'd0)     ? '0 : regs[ra_b];
   assign dbg_data = (R0_ZERO && dbg_addr == 3'd0) ? '0 : regs[dbg_addr];
endmodule

// File: rtl/fu_controller.sv
// rtl/fu_controller.sv - four-state sequencer driving the function unit and writing results back
// FU_CTRL_STATUS_EN adds the status register and COND-gated write-back on the Zr flag.
module fu_controller
   import fu_ctrl_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   output logic [DATA_W-1:0] fu_A,
   output logic [DATA_W-1:0] fu_B,
   output logic [3:0]        fu_S,
   output logic              fu_MF,
   input  logic [DATA_W-1:0] fu_data,
   input  logic              fu_V,
   input  logic              fu_C,
   input  logic              fu_Zr,
   input  logic              fu_N,
   input  logic              fu_Il,
   input  logic              fu_Ir,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic [5:0]        flags,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);
   state_t              state, state_next;
   logic [INSTR_W-1:0]  ir;
   logic [DATA_W-1:0]   rd_a, rd_b;
   logic [FLAG_W-1:0]   fu_flags;
   logic                cond_ok;
   logic                wr_en;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (instr_valid) state_next = READ;
         READ:    state_next = EXEC;
         EXEC:    state_next = WB;
         WB:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Reset in WB wins: no write and no done pulse in that cycle.
   always_comb begin
      instr_ready = (state == IDLE);
      done        = 1'b0;
      wr_en       = 1'b0;
      if (state == WB && !reset) begin
         done  = 1'b1;
         wr_en = ir[IR_WE] && cond_ok;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ir     <= '0;
         fu_A   <= '0;
         fu_B   <= '0;
         fu_S   <= 4'h0;
         fu_MF  <= 1'b0;
         result <= '0;
      end else begin
         if (state == IDLE && instr_valid) begin
            ir <= instr;
         end
         if (state == READ) begin
            fu_A  <= rd_a;
            fu_B  <= rd_b;
            fu_S  <= ir[IR_S_HI:IR_S_LO];
            fu_MF <= ir[IR_MF];
         end
         if (state == WB) begin
            result <= fu_data;
         end
      end
   end

   always_comb begin
      fu_flags          = '0;
      fu_flags[FLAG_V]  = fu_V;
      fu_flags[FLAG_C]  = fu_C;
      fu_flags[FLAG_ZR] = fu_Zr;
      fu_flags[FLAG_N]  = fu_N;
      fu_flags[FLAG_IL] = fu_Il;
      fu_flags[FLAG_IR] = fu_Ir;
   end

`ifdef FU_CTRL_STATUS_EN
   logic [FLAG_W-1:0] status;

   always_ff @(posedge clock) begin
      if (reset) begin
         status <= '0;
      end else if (state == WB) begin
         status <= fu_flags;
      end
   end

   // COND looks at Zr from the previous instruction, before this WB updates it.
   assign cond_ok = !(ir[IR_COND] && status[FLAG_ZR]);
   assign flags   = status;
`else
   logic unused_status;

   assign unused_status = ^{fu_flags, ir[IR_COND]};
   assign cond_ok       = 1'b1;
   assign flags         = '0;
`endif

   fu_regfile #(
      .DATA_W  (DATA_W),
      .R0_ZERO (R0_ZERO)
   ) u_regfile (
      .clock    (clock),
      .reset    (reset),
      .we       (wr_en),
      .wa       (ir[IR_DA_HI:IR_DA_LO]),
      .wd       (fu_data),
      .ra_a     (ir[IR_AA_HI:IR_AA_LO]),
      .ra_b     (ir[IR_BA_HI:IR_BA_LO]),
      .dbg_addr (dbg_addr),
      .rd_a     (rd_a),
      .rd_b     (rd_b),
      .dbg_data (dbg_data)
   );
endmodule

// File: tb/tb_fu_controller.sv
// tb/tb_fu_controller.sv - directed bench for fu_controller with a small function-unit model
// Expected flag/COND behaviour follows FU_CTRL_STATUS_EN.
module tb_fu_controller;
`ifdef FU_CTRL_STATUS_EN
   localparam bit STATUS_EN = 1'b1;
`else
   localparam bit STATUS_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_ready;
   logic [15:0] fu_A, fu_B, fu_data;
   logic [3:0]  fu_S;
   logic        fu_MF;
   logic        fv, fc, fz, fn, fil, fir;
   logic        done;
   logic [15:0] result;
   logic [5:0]  flags;
   logic [2:0]  dbg_addr = '0;
   logic [15:0] dbg_data;
   logic [15:0] load_val = '0;
   logic [16:0] sum17;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   fu_controller #(.DATA_W(16), .R0_ZERO(1'b1)) dut (
      .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .fu_A(fu_A), .fu_B(fu_B), .fu_S(fu_S), .fu_MF(fu_MF),
      .fu_data(fu_data), .fu_V(fv), .fu_C(fc), .fu_Zr(fz), .fu_N(fn), .fu_Il(fil), .fu_Ir(fir),
      .done(done), .result(result), .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Function-unit model: add, shift-left, and a bench-only load op (MF=0,S=F) for preloading.
   always_comb begin
      fu_data = '0;
      {fv, fc, fil, fir} = '0;
      sum17 = '0;
      if (!fu_MF && fu_S == 4'h2) begin
         sum17   = {1'b0, fu_A} + {1'b0, fu_B};
         fu_data = sum17[15:0];
         fc      = sum17[16];
         fv      = (fu_A[15] == fu_B[15]) && (sum17[15] != fu_A[15]);
      end else if (fu_MF && fu_S == 4'h1) begin
         fu_data = {fu_B[14:0], 1'b0};
         fil     = fu_B[15];
      end else if (!fu_MF && fu_S == 4'hF) begin
         fu_data = load_val;
      end
      fz = (fu_data == 16'h0000);
      fn = fu_data[15];
   end

   function automatic logic [15:0] mk(input logic mf, input logic [3:0] s, input logic [2:0] da,
                                      input logic [2:0] aa, input logic [2:0] ba,
                                      input logic we, input logic cond);
      return {mf, s, da, aa, ba, we, cond};
   endfunction

   // Starts and ends one cycle-phase after a rising edge, with the FSM back in IDLE.
   task automatic run_instr(input logic [15:0] w, output bit saw_done, output int lat);
      instr = w;
      instr_valid = 1'b1;
      @(posedge clock); #1;
      instr_valid = 1'b0;
      saw_done = 1'b0;
      lat = 0;
      while (!saw_done && lat < 8) begin
         @(negedge clock);
         if (done) saw_done = 1'b1;
         else begin
            @(posedge clock); #1;
            lat++;
         end
      end
      @(posedge clock); #1;
   endtask

   task automatic load(input logic [2:0] r, input logic [15:0] v);
      bit ok;
      int lat;
      load_val = v;
      run_instr(mk(1'b0, 4'hF, r, 3'd0, 3'd0, 1'b1, 1'b0), ok, lat);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", instr_ready); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
      vectors++; if (flags !== 6'b0) begin miscompares++; $display("FAIL reset_flags got %b want 0", flags); end
      vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL reset_result got %h want 0000", result); end
      vectors++; if ({fu_A, fu_B, fu_S, fu_MF} !== 37'h0) begin miscompares++; $display("FAIL reset_fu_out got %h/%h/%h/%b want zeros", fu_A, fu_B, fu_S, fu_MF); end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         vectors++; if (dbg_data !== 16'h0000) begin miscompares++; $display("FAIL reset_reg%0d got %h want 0000", i, dbg_data); end
      end
      @(posedge clock); #1;
   endtask

   task automatic test_add;
      load(3'd1, 16'h0003);
      load(3'd2, 16'h0004);
      dbg_addr = 3'd3;
      instr = mk(1'b0, 4'h2, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0);
      instr_valid = 1'b1;
      @(negedge clock);
      vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL add_c0_ready got %b want 1", instr_ready); end
      @(posedge clock); #1 instr_valid = 1'b0;
      @(negedge clock);
      vectors++; if ({instr_ready, done} !== 2'b00) begin miscompares++; $display("FAIL add_c1_ready_done got %b want 00", {instr_ready, done}); end
      @(negedge clock);
      vectors++; if ({fu_A, fu_B} !== {16'h0003, 16'h0004}) begin miscompares++; $display("FAIL add_c2_ops got %h %h want 0003 0004", fu_A, fu_B); end
      vectors++; if ({fu_S, fu_MF, done} !== {4'h2, 1'b0, 1'b0}) begin miscompares++; $display("FAIL add_c2_sel got S=%h MF=%b done=%b want 2 0 0", fu_S, fu_MF, done); end
      @(negedge clock);
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL add_c3_done got %b want 1", done); end
      vectors++; if ({fu_A, fu_B} !== {16'h0003, 16'h0004}) begin miscompares++; $display("FAIL add_c3_ops got %h %h want 0003 0004", fu_A, fu_B); end
      vectors++; if (dbg_data !== 16'h0000) begin miscompares++; $display("FAIL add_c3_r3 got %h want 0000", dbg_data); end
      @(negedge clock);
      vectors++; if ({instr_ready, done} !== 2'b10) begin miscompares++; $display("FAIL add_c4_ready_done got %b want 10", {instr_ready, done}); end
      vectors++; if (dbg_data !== 16'h0007) begin miscompares++; $display("FAIL add_c4_r3 got %h want 0007", dbg_data); end
      vectors++; if (result !== 16'h0007) begin miscompares++; $display("FAIL add_c4_result got %h want 0007", result); end
      vectors++; if (flags !== 6'b0) begin miscompares++; $display("FAIL add_flags got %b want 000000", flags); end
      @(posedge clock); #1;
   endtask

   task automatic test_shift;
      bit ok;
      int lat;
      load(3'd2, 16'h8001);
      dbg_addr = 3'd2; #1;
      vectors++; if (dbg_data !== 16'h8001) begin miscompares++; $display("FAIL shift_preload got %h want 8001", dbg_data); end
      run_instr(mk(1'b1, 4'h1, 3'd2, 3'd0, 3'd2, 1'b1, 1'b0), ok, lat);
      vectors++; if (!ok || lat != 2) begin miscompares++; $display("FAIL shift_done got seen=%b lat=%0d want 1 2", ok, lat); end
      vectors++; if (dbg_data !== 16'h0002) begin miscompares++; $display("FAIL shift_r2 got %h want 0002", dbg_data); end
      vectors++; if (result !== 16'h0002) begin miscompares++; $display("FAIL shift_result got %h want 0002", result); end
      vectors++; if (flags !== (STATUS_EN ? 6'b000010 : 6'b0)) begin miscompares++; $display("FAIL shift_flags got %b want %b", flags, STATUS_EN ? 6'b000010 : 6'b0); end
   endtask

   task automatic test_no_write;
      bit ok;
      int lat;
      dbg_addr = 3'd4;
      run_instr(mk(1'b0, 4'h2, 3'd4, 3'd1, 3'd3, 1'b0, 1'b0), ok, lat);
      vectors++; if (!ok) begin miscompares++; $display("FAIL we0_done got 0 want 1"); end
      vectors++; if (result !== 16'h000A) begin miscompares++; $display("FAIL we0_result got %h want 000a", result); end
      vectors++; if (dbg_data !== 16'h0000) begin miscompares++; $display("FAIL we0_r4 got %h want 0000", dbg_data); end
      dbg_addr = 3'd0;
      run_instr(mk(1'b0, 4'h2, 3'd0, 3'd1, 3'd1, 1'b1, 1'b0), ok, lat);
      vectors++; if (!ok) begin miscompares++; $display("FAIL da0_done got 0 want 1"); end
      vectors++; if (result !== 16'h0006) begin miscompares++; $display("FAIL da0_result got %h want 0006", result); end
      vectors++; if (dbg_data !== 16'h0000) begin miscompares++; $display("FAIL da0_r0 got %h want 0000", dbg_data); end
      dbg_addr = 3'd1; #1;
      vectors++; if (dbg_data !== 16'h0003) begin miscompares++; $display("FAIL da0_r1 got %h want 0003", dbg_data); end
   endtask

   task automatic test_cond;
      bit ok;
      int lat;
      dbg_addr = 3'd4;
      run_instr(mk(1'b0, 4'h2, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0), ok, lat);
      vectors++; if (flags !== (STATUS_EN ? 6'b001000 : 6'b0)) begin miscompares++; $display("FAIL cond_zero_flags got %b want %b", flags, STATUS_EN ? 6'b001000 : 6'b0); end
      run_instr(mk(1'b0, 4'h2, 3'd4, 3'd1, 3'd3, 1'b1, 1'b1), ok, lat);
      vectors++; if (!ok) begin miscompares++; $display("FAIL cond_done got 0 want 1"); end
      vectors++; if (result !== 16'h000A) begin miscompares++; $display("FAIL cond_result got %h want 000a", result); end
      vectors++; if (dbg_data !== (STATUS_EN ? 16'h0000 : 16'h000A)) begin miscompares++; $display("FAIL cond_suppress_r4 got %h want %h", dbg_data, STATUS_EN ? 16'h0000 : 16'h000A); end
      run_instr(mk(1'b0, 4'h2, 3'd4, 3'd1, 3'd3, 1'b1, 1'b1), ok, lat);
      vectors++; if (dbg_data !== 16'h000A) begin miscompares++; $display("FAIL cond_pass_r4 got %h want 000a", dbg_data); end
      vectors++; if (flags !== 6'b0) begin miscompares++; $display("FAIL cond_pass_flags got %b want 000000", flags); end
   endtask

   task automatic test_back_to_back;
      int d_first = -1;
      int d_second = -1;
      int n_done = 0;
      load(3'd1, 16'h0011);
      instr = mk(1'b0, 4'h2, 3'd6, 3'd1, 3'd1, 1'b1, 1'b0);
      instr_valid = 1'b1;
      @(posedge clock); #1;
      instr = mk(1'b0, 4'h2, 3'd7, 3'd6, 3'd6, 1'b1, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock);
         if (done) begin
            n_done++;
            if (d_first < 0) d_first = c; else d_second = c;
         end
      end
      instr_valid = 1'b0;
      @(posedge clock); #1;
      vectors++; if (n_done != 2 || d_first != 3 || d_second != 7) begin miscompares++; $display("FAIL b2b_done_cycles got n=%0d at %0d,%0d want 2 at 3,7", n_done, d_first, d_second); end
      dbg_addr = 3'd7; #1;
      vectors++; if (dbg_data !== 16'h0044) begin miscompares++; $display("FAIL b2b_r7 got %h want 0044", dbg_data); end
   endtask

   task automatic test_reset_exec;
      bit seen_done = 1'b0;
      dbg_addr = 3'd5;
      instr = mk(1'b1, 4'h1, 3'd5, 3'd1, 3'd1, 1'b1, 1'b0);
      instr_valid = 1'b1;
      @(posedge clock); #1 instr_valid = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
      @(negedge clock);
      if (done) seen_done = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         if (done) seen_done = 1'b1;
         if (c == 0) begin
            vectors++; if ({instr_ready, fu_A, fu_B, fu_S, fu_MF} !== {1'b1, 37'h0}) begin miscompares++; $display("FAIL rst_exec_outs got rdy=%b A=%h B=%h S=%h MF=%b want 1 0 0 0 0", instr_ready, fu_A, fu_B, fu_S, fu_MF); end
            vectors++; if ({result, flags} !== 22'h0) begin miscompares++; $display("FAIL rst_exec_result_flags got %h %b want 0000 000000", result, flags); end
            vectors++; if (dbg_data !== 16'h0000) begin miscompares++; $display("FAIL rst_exec_r5 got %h want 0000", dbg_data); end
         end
      end
      vectors++; if (seen_done !== 1'b0) begin miscompares++; $display("FAIL rst_exec_done got 1 want 0"); end
      dbg_addr = 3'd1; #1;
      vectors++; if (dbg_data !== 16'h0000) begin miscompares++; $display("FAIL rst_exec_r1 got %h want 0000", dbg_data); end
   endtask

   initial begin
      test_reset;
      test_add;
      test_shift;
      test_no_write;
      test_cond;
      test_back_to_back;
      test_reset_exec;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0d vectors", vectors);
      $fatal(1);
   end
endmodule
